// File: rtl/inv_round.sv
// inv_round: one AES inverse-cipher round (InvShiftRows, InvSubBytes,
// AddRoundKey, optional InvMixColumns) as a three-stage pipeline that
// accepts one 128-bit state per cycle.
//
// Ports:
//   clk               rising-edge clock
//   rst               synchronous active-low reset
//   data_in           round input state, byte 0 in [127:120], column-major
//   key               round key, captured together with data_in
//   i_en              input valid; data_in/key/skip captured when high
//   skip_inv_mix_cols 1 = final inverse round, InvMixColumns bypassed
//   o_en              output valid, one cycle per accepted block
//   data_out          round result, held while o_en is low
module inv_round (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] data_in,
    input  logic [127:0] key,
    input  logic         i_en,
    input  logic         skip_inv_mix_cols,
    output logic         o_en,
    output logic [127:0] data_out
);

    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Each byte needs x2, x4, x8; the four matrix constants are XORs of those.
    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a  [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        logic [7:0] x2, x4, x8;
        logic [31:0] res;
        res = '0;
        for (int i = 0; i < 4; i++) begin
            a[i]  = col[31-8*i -: 8];
            x2    = xtime(a[i]);
            x4    = xtime(x2);
            x8    = xtime(x4);
            m9[i] = x8 ^ a[i];
            mb[i] = x8 ^ x2 ^ a[i];
            md[i] = x8 ^ x4 ^ a[i];
            me[i] = x8 ^ x4 ^ x2;
        end
        // Row r of the matrix is {0e 0b 0d 09} rotated right by r.
        for (int r = 0; r < 4; r++) begin
            res[31-8*r -: 8] = me[r] ^ mb[(r+1)%4] ^ md[(r+2)%4] ^ m9[(r+3)%4];
        end
        return res;
    endfunction

    logic [127:0] s1_state_q, s1_state_d, s1_key_q;
    logic         s1_skip_q, s1_vld_q;
    logic [127:0] s2_state_q, s2_state_d;
    logic         s2_skip_q, s2_vld_q;
    logic [127:0] s3_state_q, s3_state_d;
    logic         s3_vld_q;

    // InvShiftRows: output (row r, col c) takes input (row r, col c-r).
    always_comb begin
        s1_state_d = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                s1_state_d[127-8*(r+4*c) -: 8] =
                    INV_SBOX[data_in[127-8*(r+4*((c-r+4)%4)) -: 8]];
            end
        end
    end

    assign s2_state_d = s1_state_q ^ s1_key_q;

    always_comb begin
        s3_state_d = s2_state_q;
        if (!s2_skip_q) begin
            for (int c = 0; c < 4; c++) begin
                s3_state_d[127-32*c -: 32] = inv_mix_col(s2_state_q[127-32*c -: 32]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_state_q <= '0;
            s1_key_q   <= '0;
            s1_skip_q  <= 1'b0;
            s1_vld_q   <= 1'b0;
            s2_state_q <= '0;
            s2_skip_q  <= 1'b0;
            s2_vld_q   <= 1'b0;
            s3_state_q <= '0;
            s3_vld_q   <= 1'b0;
        end else begin
            s1_vld_q <= i_en;
            s2_vld_q <= s1_vld_q;
            s3_vld_q <= s2_vld_q;
            if (i_en) begin
                s1_state_q <= s1_state_d;
                s1_key_q   <= key;
                s1_skip_q  <= skip_inv_mix_cols;
            end
            if (s1_vld_q) begin
                s2_state_q <= s2_state_d;
                s2_skip_q  <= s1_skip_q;
            end
            if (s2_vld_q) begin
                s3_state_q <= s3_state_d;
            end
        end
    end

    assign o_en     = s3_vld_q;
    assign data_out = s3_state_q;

endmodule

// File: tb/tb_inv_round.sv
// Directed bench for inv_round: a scoreboard queue receives the expected
// round result for every accepted block, and each cycle the output valid
// and data are compared against an independent model of the pipeline.
module tb_inv_round;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] data_in;
    logic [127:0] key;
    logic         i_en;
    logic         skip_inv_mix_cols;
    logic         o_en;
    logic [127:0] data_out;

    inv_round dut (
        .clk               (clk),
        .rst               (rst),
        .data_in           (data_in),
        .key               (key),
        .i_en              (i_en),
        .skip_inv_mix_cols (skip_inv_mix_cols),
        .o_en              (o_en),
        .data_out          (data_out)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [127:0] sb [$];
    logic [2:0]   vld_pipe = 3'b000;
    logic [127:0] last_out = '0;
    logic [127:0] drv_exp  = '0;
    logic [7:0]   isb [256];

    localparam logic [127:0] V1_D = 128'h7ad5fda789ef4e272bca100b3d9ff59f;
    localparam logic [127:0] V1_K = 128'h549932d1f08557681093ed9cbe2c974e;
    localparam logic [127:0] V1_R = 128'h54d990a16ba09ab596bbf40ea111702f;
    localparam logic [127:0] V1_S1 = 128'hbd6e7c3df2b5779e0b61216e8b10b689;
    localparam logic [127:0] V1_S2 = 128'he9f74eec023020f61bf2ccf2353c21c7;
    localparam logic [127:0] V2_D = 128'h6353e08c0960e104cd70b751bacad0e7;
    localparam logic [127:0] V2_K = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] V2_R = 128'h00112233445566778899aabbccddeeff;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        p = 8'h00; aa = a; bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        logic [15:0] w;
        w = {b, b};
        return w[15-n -: 8];
    endfunction

    // Inverse S-box derived from the forward S-box definition (GF inverse + affine).
    task automatic build_isb();
        logic [7:0] inv, s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            s = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
            isb[s] = 8'(x);
        end
    endtask

    function automatic logic [127:0] model(input logic [127:0] d, input logic [127:0] k, input logic skip);
        logic [7:0] a [16];
        logic [7:0] b [16];
        logic [7:0] m [4];
        logic [7:0] v;
        logic [127:0] res;
        m[0] = 8'h0e; m[1] = 8'h0b; m[2] = 8'h0d; m[3] = 8'h09;
        for (int i = 0; i < 16; i++) a[i] = d[127-8*i -: 8];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                b[r+4*c] = isb[a[r+4*((c-r+4)%4)]] ^ k[127-8*(r+4*c) -: 8];
        res = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
                if (skip) v = b[r+4*c];
                else begin
                    v = 8'h00;
                    for (int j = 0; j < 4; j++) v = v ^ gmul(m[(j-r+4)%4], b[j+4*c]);
                end
                res[127-8*(r+4*c) -: 8] = v;
            end
        return res;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic en, input logic [127:0] d, input logic [127:0] k,
                         input logic skip, input logic [127:0] expv);
        i_en = en; data_in = d; key = k; skip_inv_mix_cols = skip; drv_exp = expv;
    endtask

    task automatic drive_rand(input logic en);
        logic [127:0] d, k;
        logic s;
        d = {$urandom, $urandom, $urandom, $urandom};
        k = {$urandom, $urandom, $urandom, $urandom};
        s = 1'($urandom_range(0, 1));
        drive(en, d, k, s, model(d, k, s));
    endtask

    // One clock edge: update the reference pipeline, then compare outputs.
    task automatic tick();
        logic acc;
        acc = rst && i_en;
        if (acc) sb.push_back(drv_exp);
        @(posedge clk);
        #1;
        if (!rst) begin
            vld_pipe = 3'b000;
            sb.delete();
            last_out = '0;
        end else begin
            vld_pipe = {vld_pipe[1:0], acc};
        end
        check("o_en", {127'd0, o_en}, {127'd0, vld_pipe[2]});
        if (vld_pipe[2] && sb.size() > 0) last_out = sb.pop_front();
        check("data_out", data_out, last_out);
    endtask

    initial begin
        build_isb();
        rst = 1'b0;
        drive(1'b0, '0, '0, 1'b0, '0);
        tick(); tick();
        rst = 1'b1;
        tick();

        // Middle round with stage probes; key/skip scrambled after accept.
        drive(1'b1, V1_D, V1_K, 1'b0, V1_R);
        tick();
        check("s1_state", dut.s1_state_q, V1_S1);
        drive(1'b0, ~V1_D, ~V1_K, 1'b1, '0);
        tick();
        check("s2_state", dut.s2_state_q, V1_S2);
        tick(); tick(); tick();

        // Final round.
        drive(1'b1, V2_D, V2_K, 1'b1, V2_R);
        tick();
        drive(1'b0, '0, '0, 1'b0, '0);
        tick(); tick(); tick(); tick();

        // Back-to-back, mixed skip, key toggled after the last accept.
        drive(1'b1, V1_D, V1_K, 1'b0, V1_R);
        tick();
        drive(1'b1, V2_D, V2_K, 1'b1, V2_R);
        tick();
        drive(1'b0, V2_D, V1_K, 1'b0, '0);
        tick();
        drive(1'b0, V1_D, V2_K, 1'b1, '0);
        tick(); tick(); tick();

        // Bubbles 1,0,1,1,0 with random vectors, repeated.
        for (int rep = 0; rep < 4; rep++) begin
            drive_rand(1'b1); tick();
            drive_rand(1'b0); tick();
            drive_rand(1'b1); tick();
            drive_rand(1'b1); tick();
            drive_rand(1'b0); tick();
        end
        drive(1'b0, '0, '0, 1'b0, '0);
        tick(); tick(); tick();

        // Reset mid-flight, then accept on the first edge out of reset.
        drive(1'b1, V1_D, V1_K, 1'b0, V1_R);
        tick();
        drive(1'b1, V2_D, V2_K, 1'b1, V2_R);
        tick();
        rst = 1'b0;
        drive(1'b0, '0, '0, 1'b0, '0);
        tick();
        check("data_out_after_reset", data_out, 128'd0);
        rst = 1'b1;
        drive(1'b1, V2_D, V2_K, 1'b1, V2_R);
        tick();
        drive(1'b0, '0, '0, 1'b0, '0);
        tick(); tick(); tick(); tick();

        // Reset collides with an accept.
        rst = 1'b0;
        drive(1'b1, V1_D, V1_K, 1'b0, V1_R);
        tick();
        rst = 1'b1;
        drive(1'b0, '0, '0, 1'b0, '0);
        tick(); tick(); tick(); tick(); tick();

        checks++;
        assert (sb.size() == 0) else begin
            failures++;
            $error("FAIL scoreboard_drain observed=%0d expected=0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
